// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end definitions: NOP encoding, IF/ID state encodings,
// instruction field positions and default datapath widths.
package legv8_pkg;

  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_INSTR_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    VALID = 2'd1,
    HELD  = 2'd2
  } ifIdState_t;

  // Register-field bit positions shared by every decode-side consumer.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 21;
  localparam int RM_MSB  = 20;
  localparam int RM_LSB  = 16;
  localparam int RN_MSB  = 9;
  localparam int RN_LSB  = 5;
  localparam int RT_MSB  = 4;
  localparam int RT_LSB  = 0;

endpackage

// File: rtl/instr_field_slicer.sv
// Combinational split of a LEGv8 instruction word into opcode and register
// fields; shared by the IF/ID and ID/EX stages.
module instr_field_slicer
  import legv8_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [10:0] o_opcode,
  output logic [4:0]  o_rn,
  output logic [4:0]  o_rm,
  output logic [4:0]  o_rt
);

  assign o_opcode = i_instr[OPC_MSB:OPC_LSB];
  assign o_rn     = i_instr[RN_MSB:RN_LSB];
  assign o_rm     = i_instr[RM_MSB:RM_LSB];
  assign o_rt     = i_instr[RT_MSB:RT_LSB];

endmodule

// File: rtl/if_id_register.sv
// Fetch/decode pipeline register with stall (hold), flush (bubble) and a
// valid bit; register fields are sliced from the captured instruction.
module if_id_register #(
  parameter int                ADDR_W    = legv8_pkg::DEF_ADDR_W,
  parameter int                INSTR_W   = legv8_pkg::DEF_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = legv8_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pcIn,
  input  logic [INSTR_W-1:0] instrIn,
  output logic [ADDR_W-1:0]  pcOut,
  output logic [ADDR_W-1:0]  pcPlus4Out,
  output logic [INSTR_W-1:0] instrOut,
  output logic [10:0]        opcodeOut,
  output logic [4:0]         rnOut,
  output logic [4:0]         rmOut,
  output logic [4:0]         rtOut,
  output logic               validOut,
  output logic [1:0]         state
);

  import legv8_pkg::*;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_pcPlus4;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  ifIdState_t         r_state;
  logic [ADDR_W-1:0]  w_pcPlus4;

  assign w_pcPlus4 = pcIn + ADDR_W'(4);

  // Flush wins over stall so the hazard unit can bubble a stalled slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= '0;
      r_pcPlus4 <= '0;
      r_instr   <= NOP_INSTR;
      r_valid   <= 1'b0;
      r_state   <= EMPTY;
    end else if (flush) begin
      r_pc      <= pcIn;
      r_pcPlus4 <= w_pcPlus4;
      r_instr   <= NOP_INSTR;
      r_valid   <= 1'b0;
      r_state   <= EMPTY;
    end else if (stall) begin
      case (r_state)
        VALID, HELD: r_state <= HELD;
        default:     r_state <= EMPTY;
      endcase
    end else begin
      r_pc      <= pcIn;
      r_pcPlus4 <= w_pcPlus4;
      r_instr   <= instrIn;
      r_valid   <= 1'b1;
      r_state   <= VALID;
    end
  end

  assign pcOut      = r_pc;
  assign pcPlus4Out = r_pcPlus4;
  assign instrOut   = r_instr;
  assign validOut   = r_valid;
  assign state      = r_state;

  instr_field_slicer u_slicer (
    .i_instr  (r_instr[31:0]),
    .o_opcode (opcodeOut),
    .o_rn     (rnOut),
    .o_rm     (rmOut),
    .o_rt     (rtOut)
  );

endmodule

// File: tb/tb_if_id_register.sv
// Directed and small randomized checks of the IF/ID pipeline register.
module tb_if_id_register;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [63:0] pcIn;
  logic [31:0] instrIn;
  logic [63:0] pcOut;
  logic [63:0] pcPlus4Out;
  logic [31:0] instrOut;
  logic [10:0] opcodeOut;
  logic [4:0]  rnOut;
  logic [4:0]  rmOut;
  logic [4:0]  rtOut;
  logic        validOut;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'hD503201F;

  if_id_register dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .pcIn       (pcIn),
    .instrIn    (instrIn),
    .pcOut      (pcOut),
    .pcPlus4Out (pcPlus4Out),
    .instrOut   (instrOut),
    .opcodeOut  (opcodeOut),
    .rnOut      (rnOut),
    .rmOut      (rmOut),
    .rtOut      (rtOut),
    .validOut   (validOut),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Advance through one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    pcIn = 64'h0; instrIn = 32'h8B020020;
    #12;
    checks++;
    if (pcOut !== 64'h0 || pcPlus4Out !== 64'h0 || instrOut !== NOP) begin
      errors++;
      $display("[TB] FAIL reset_regs pc=%h pc4=%h instr=%h expected 0/0/%h", pcOut, pcPlus4Out, instrOut, NOP);
    end
    checks++;
    if (validOut !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl valid=%b state=%0d expected 0/0", validOut, state);
    end
    checks++;
    if (opcodeOut !== 11'h6A8 || rnOut !== 5'd0 || rmOut !== 5'd3 || rtOut !== 5'd31) begin
      errors++;
      $display("[TB] FAIL reset_fields opc=%h rn=%0d rm=%0d rt=%0d expected 6a8/0/3/31", opcodeOut, rnOut, rmOut, rtOut);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load();
    step();
    checks++;
    if (pcOut !== 64'h0 || pcPlus4Out !== 64'h4 || instrOut !== 32'h8B020020) begin
      errors++;
      $display("[TB] FAIL load_regs pc=%h pc4=%h instr=%h expected 0/4/8b020020", pcOut, pcPlus4Out, instrOut);
    end
    checks++;
    if (opcodeOut !== 11'h458 || rnOut !== 5'd1 || rmOut !== 5'd2 || rtOut !== 5'd0) begin
      errors++;
      $display("[TB] FAIL load_fields opc=%h rn=%0d rm=%0d rt=%0d expected 458/1/2/0", opcodeOut, rnOut, rmOut, rtOut);
    end
    checks++;
    if (validOut !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("[TB] FAIL load_ctrl valid=%b state=%0d expected 1/1", validOut, state);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    stall = 1'b1; pcIn = 64'h8; instrIn = 32'hF8400000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instrOut !== 32'h8B020020 || pcOut !== 64'h0 || pcPlus4Out !== 64'h4 ||
          validOut !== 1'b1 || state !== 2'd2) begin
        errors++;
        $display("[TB] FAIL stall_hold cycle=%0d instr=%h pc=%h pc4=%h valid=%b state=%0d expected 8b020020/0/4/1/2",
                 i, instrOut, pcOut, pcPlus4Out, validOut, state);
      end
    end
    @(negedge clk);
    stall = 1'b0;
    step();
    checks++;
    if (instrOut !== 32'hF8400000 || pcOut !== 64'h8 || pcPlus4Out !== 64'hC || state !== 2'd1) begin
      errors++;
      $display("[TB] FAIL stall_release instr=%h pc=%h pc4=%h state=%0d expected f8400000/8/c/1",
               instrOut, pcOut, pcPlus4Out, state);
    end
  endtask

  task automatic test_flush_stall();
    @(negedge clk);
    stall = 1'b1; flush = 1'b1; pcIn = 64'h40; instrIn = 32'h8B020020;
    step();
    checks++;
    if (instrOut !== NOP || validOut !== 1'b0 || pcOut !== 64'h40 || pcPlus4Out !== 64'h44 || state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL flush_stall instr=%h valid=%b pc=%h pc4=%h state=%0d expected %h/0/40/44/0",
               instrOut, validOut, pcOut, pcPlus4Out, state, NOP);
    end
    @(negedge clk);
    flush = 1'b0;
    step();
    checks++;
    if (validOut !== 1'b0 || state !== 2'd0 || instrOut !== NOP) begin
      errors++;
      $display("[TB] FAIL stall_empty valid=%b state=%0d instr=%h expected 0/0/%h", validOut, state, instrOut, NOP);
    end
    @(negedge clk);
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    pcIn = 64'hFFFF_FFFF_FFFF_FFFC; instrIn = 32'h91000421;
    step();
    checks++;
    if (pcPlus4Out !== 64'h0 || pcOut !== 64'hFFFF_FFFF_FFFF_FFFC || validOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pc_wrap pc=%h pc4=%h valid=%b expected fffffffffffffffc/0/1", pcOut, pcPlus4Out, validOut);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    stall = 1'b1;
    step();
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("[TB] FAIL pre_reset_held state=%0d expected 2", state);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (pcOut !== 64'h0 || pcPlus4Out !== 64'h0 || instrOut !== NOP || validOut !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL async_reset pc=%h pc4=%h instr=%h valid=%b state=%0d expected 0/0/%h/0/0",
               pcOut, pcPlus4Out, instrOut, validOut, state, NOP);
    end
    @(negedge clk);
    reset = 1'b0; stall = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] mPc = 64'h0;
    logic [63:0] mPc4 = 64'h0;
    logic [31:0] mInstr = NOP;
    logic        mValid = 1'b0;
    logic [1:0]  mState = 2'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      stall   = ($urandom_range(0, 2) == 0);
      flush   = ($urandom_range(0, 4) == 0);
      pcIn    = {$urandom, $urandom} & ~64'h3;
      instrIn = $urandom;
      if (flush) begin
        mPc = pcIn; mPc4 = pcIn + 64'd4; mInstr = NOP; mValid = 1'b0; mState = 2'd0;
      end else if (stall) begin
        mState = (mState == 2'd0) ? 2'd0 : 2'd2;
      end else begin
        mPc = pcIn; mPc4 = pcIn + 64'd4; mInstr = instrIn; mValid = 1'b1; mState = 2'd1;
      end
      step();
      checks++;
      if (pcOut !== mPc || pcPlus4Out !== mPc4 || instrOut !== mInstr || validOut !== mValid ||
          state !== mState || rtOut !== mInstr[4:0] || opcodeOut !== mInstr[31:21]) begin
        errors++;
        $display("[TB] FAIL random cycle=%0d pc=%h/%h pc4=%h/%h instr=%h/%h valid=%b/%b state=%0d/%0d (got/expected)",
                 i, pcOut, mPc, pcPlus4Out, mPc4, instrOut, mInstr, validOut, mValid, state, mState);
      end
    end
    @(negedge clk);
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_register.md
Name: if_id_register

Overview:
- Fetch/decode pipeline register of the pipelined LEGv8 core.
- Sits directly downstream of the PC register and instruction memory.
- Captures the fetched PC, PC+4 and the 32-bit instruction each cycle, and pre-slices the register fields for the decode stage.
- Supports stall (hold), flush (bubble insertion) and a valid bit, so hazard and branch logic can control the front end.

Parameters:
- ADDR_W, 64, PC/address width
- INSTR_W, 32, instruction width
- NOP_INSTR, 32'hD503201F, encoding inserted on bubble/reset

Ports:
- clk  input  1  rising-edge clock, shared with the PC register
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold all outputs this cycle (load-use hazard)
- flush  input  1  discard the instruction being captured (taken branch)
- pcIn  input  ADDR_W  address currently driven by the PC register
- instrIn  input  INSTR_W  instruction memory read data for pcIn
- pcOut  output  ADDR_W  registered PC of the decode-stage instruction
- pcPlus4Out  output  ADDR_W  registered pcIn+4, computed modulo 2^64
- instrOut  output  INSTR_W  registered instruction
- opcodeOut  output  11  instrOut[31:21]
- rnOut  output  5  instrOut[9:5]
- rmOut  output  5  instrOut[20:16]
- rtOut  output  5  instrOut[4:0] (Rd/Rt)
- validOut  output  1  decode stage holds a real instruction
- state  output  2  FSM state, for debug and verification

Behaviour:
- Reset, asynchronous and immediate on assertion:
  - pcOut=0, pcPlus4Out=0, instrOut=NOP_INSTR, validOut=0, state=EMPTY.
  - Field outputs reflect NOP_INSTR.
- The first capture occurs on the first rising clk edge after reset deasserts.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Field outputs are combinational slices of instrOut. They are never taken from instrIn.
- FSM states: EMPTY=0, VALID=1, HELD=2. Encoding 3 is illegal and is treated as EMPTY on the next edge.
- Priority per edge: reset > flush > stall > load.
- flush=1, regardless of stall:
  - instrOut=NOP_INSTR, validOut=0, pcOut/pcPlus4Out load pcIn/pcIn+4.
  - state goes to EMPTY.
  - Flush during stall still inserts the bubble; this is deliberate and the hazard unit relies on it.
- flush=0, stall=1:
  - All outputs hold.
  - state goes VALID->HELD or HELD->HELD. EMPTY stays EMPTY, with validOut still 0.
- flush=0, stall=0:
  - Load pcIn, pcIn+4 and instrIn; validOut=1; state goes to VALID from any state.
- pcPlus4 wrap-around: pcIn=64'hFFFF_FFFF_FFFF_FFFC gives pcPlus4Out=0, with no flag.
- pcIn=-4 (the PC register's power-on value) is captured like any other address. There is no special case.
- Reset asserted mid-stall or mid-flush: outputs go to reset values immediately; pending stall/flush requests are lost.
- No combinational path from stall/flush to any output.

Decomposition:
- Shared package (legv8_pkg):
  - NOP_INSTR constant
  - FSM state encodings EMPTY/VALID/HELD
  - opcode field bit positions
  - ADDR_W/INSTR_W defaults
- Sub-module: one small combinational helper, instr_field_slicer, mapping instrOut to opcode/rn/rm/rt. It is reused later by the ID/EX stage.
- The register and FSM stay in if_id_register.

Test Plan:
- Reset then release, pcIn=0x0, instrIn=0x8B020020, stall=flush=0 -> after 1 edge: pcOut=0x0, pcPlus4Out=0x4, instrOut=0x8B020020, opcodeOut=0x458, rnOut=1, rmOut=2, rtOut=0, validOut=1, state=VALID.
- Loaded 0x8B020020, then stall=1 for 3 edges with instrIn=0xF8400000 -> outputs unchanged, state=HELD; stall=0 -> next edge loads 0xF8400000, state=VALID.
- flush=1 and stall=1 on the same edge, pcIn=0x40 -> instrOut=0xD503201F, validOut=0, pcOut=0x40, state=EMPTY.
- pcIn=0xFFFF_FFFF_FFFF_FFFC, no stall/flush -> pcPlus4Out=0x0, validOut=1.
- Assert reset asynchronously, between edges, while state=HELD -> outputs take reset values before the next clk edge; state=EMPTY.
- Sequence of 20 random load/stall/flush cycles vs. a reference model -> outputs match every cycle; validOut=0 exactly on the cycles after flush and while EMPTY.
